// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared iterative multiply/divide unit: issues load/step
// strobes, stalls the execute stage while busy and traps divide-by-zero up front.
module muldiv_sequencer #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic       i_divisor_zero,
  input  logic       i_flush,
  output logic       o_stall_c,
  output logic       o_unit_load,
  output logic       o_unit_step,
  output logic       o_unit_signed,
  output logic       o_unit_is_div,
  output logic       o_done,
  output logic       o_div_zero_fault
);

  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_unit_signed;
  logic               r_unit_is_div;
  logic               w_signed_nxt;
  logic               w_is_div_nxt;
  logic               r_unit_load;
  logic               r_unit_step;
  logic               r_done;
  logic               r_div_zero_fault;

  // State, step counter and captured operation
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_unit_signed    <= 1'b0;
      r_unit_is_div    <= 1'b0;
      r_unit_load      <= 1'b0;
      r_unit_step      <= 1'b0;
      r_done           <= 1'b0;
      r_div_zero_fault <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_unit_signed    <= w_signed_nxt;
      r_unit_is_div    <= w_is_div_nxt;
      r_unit_load      <= (w_state_nxt == S_LOAD);
      r_unit_step      <= (w_state_nxt == S_RUN);
      r_done           <= (w_state_nxt == S_DONE);
      r_div_zero_fault <= (w_state_nxt == S_FAULT);
    end
  end

  // Next-state and counter logic; flush overrides everything
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_signed_nxt = r_unit_signed;
    w_is_div_nxt = r_unit_is_div;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_signed_nxt = i_op[0];
          w_is_div_nxt = i_op[1];
          w_state_nxt  = (i_op[1] && i_divisor_zero) ? S_FAULT : S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt_nxt   = r_unit_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
        // A zero count cannot occur normally; leaving on it avoids a lockup
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_FAULT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (i_flush) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
      w_signed_nxt = r_unit_signed;
      w_is_div_nxt = r_unit_is_div;
    end
  end

  // Stall drops in DONE so the pipeline captures the result that cycle
  assign o_stall_c = !i_reset &&
                     ((i_start && !i_flush && (r_state == S_IDLE)) ||
                      (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_FAULT));

  assign o_unit_load      = r_unit_load;
  assign o_unit_step      = r_unit_step;
  assign o_unit_signed    = r_unit_signed;
  assign o_unit_is_div    = r_unit_is_div;
  assign o_done           = r_done;
  assign o_div_zero_fault = r_div_zero_fault;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and randomized requests
// compared cycle by cycle against a latency-based reference model.
module tb_muldiv_sequencer;

  localparam int unsigned DIV_N = 32;
  localparam int unsigned MUL_N = 4;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [1:0] i_op;
  logic       i_divisor_zero;
  logic       i_flush;
  logic       o_stall_c;
  logic       o_unit_load;
  logic       o_unit_step;
  logic       o_unit_signed;
  logic       o_unit_is_div;
  logic       o_done;
  logic       o_div_zero_fault;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done_seen = 0;
  int n_accepted  = 0;

  // Model of the architecturally visible captured op bits
  logic m_sgn;
  logic m_isdiv;

  muldiv_sequencer #(.DIV_CYCLES(DIV_N), .MUL_CYCLES(MUL_N)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_op             (i_op),
    .i_divisor_zero   (i_divisor_zero),
    .i_flush          (i_flush),
    .o_stall_c        (o_stall_c),
    .o_unit_load      (o_unit_load),
    .o_unit_step      (o_unit_step),
    .o_unit_signed    (o_unit_signed),
    .o_unit_is_div    (o_unit_is_div),
    .o_done           (o_done),
    .o_div_zero_fault (o_div_zero_fault)
  );

  always #5 i_clk = ~i_clk;

  // {load, step, done, fault, stall, signed, is_div}
  function automatic logic [6:0] obs();
    return {o_unit_load, o_unit_step, o_done, o_div_zero_fault, o_stall_c, o_unit_signed, o_unit_is_div};
  endfunction

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // One request from IDLE; each cycle compared to the latency rules.
  task automatic run_request(input logic [1:0] op, input logic dz, input bit noise, input string tag);
    logic [6:0] exp_v;
    logic [6:0] got;
    bit         fault;
    int         n;
    int         last;
    fault = op[1] && dz;
    n     = op[1] ? DIV_N : MUL_N;
    last  = fault ? 1 : n + 2;

    i_start = 1'b1; i_op = op; i_divisor_zero = dz; i_flush = 1'b0;
    #3;
    exp_v = {4'b0000, 1'b1, m_sgn, m_isdiv};
    got = obs();
    n_cmp++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s k=0 got=%b exp=%b", tag, got, exp_v);
    end
    m_sgn = op[0]; m_isdiv = op[1];
    n_accepted++;

    for (int k = 1; k <= last; k++) begin
      cyc();
      i_start        = noise ? 1'($urandom_range(1)) : 1'b0;
      i_op           = 2'($urandom_range(3));
      i_divisor_zero = 1'($urandom_range(1));
      #3;
      exp_v[6] = !fault && (k == 1);
      exp_v[5] = !fault && (k >= 2) && (k <= n + 1);
      exp_v[4] = !fault && (k == n + 2);
      exp_v[3] = fault && (k == 1);
      exp_v[2] = fault ? (k == 1) : (k <= n + 1);
      exp_v[1] = m_sgn;
      exp_v[0] = m_isdiv;
      got = obs();
      if (o_done === 1'b1) n_done_seen++;
      n_cmp++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp_v);
      end
    end

    // Back in IDLE with no request: everything quiet
    cyc();
    i_start = 1'b0;
    #3;
    exp_v = {5'b00000, m_sgn, m_isdiv};
    got = obs();
    n_cmp++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s idle got=%b exp=%b", tag, got, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [6:0] got;
    i_reset = 1'b1; i_start = 1'b1; i_op = 2'b11; i_divisor_zero = 1'b0; i_flush = 1'b0;
    #3;
    n_cmp++;
    if (o_stall_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall got=%b exp=0", o_stall_c);
    end
    cyc(); cyc();
    #3;
    got = obs();
    n_cmp++;
    if (got !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", got, 7'b0);
    end
    i_reset = 1'b0; i_start = 1'b0;
    m_sgn = 1'b0; m_isdiv = 1'b0;
    cyc();
  endtask

  task automatic test_directed();
    run_request(2'b10, 1'b0, 1'b0, "udiv");
    run_request(2'b01, 1'b0, 1'b0, "smul");
    run_request(2'b11, 1'b1, 1'b0, "sdiv_zero");
    run_request(2'b00, 1'b1, 1'b0, "umul_dz_ignored");
    run_request(2'b11, 1'b0, 1'b0, "sdiv");
    run_request(2'b10, 1'b1, 1'b0, "udiv_zero");
  endtask

  task automatic test_flush();
    logic [6:0] got;
    i_start = 1'b1; i_op = 2'b10; i_divisor_zero = 1'b0; i_flush = 1'b0;
    m_sgn = 1'b0; m_isdiv = 1'b1;
    // k=1 LOAD, RUN cycles begin at k=2; 10th RUN cycle is k=11
    for (int k = 1; k <= 11; k++) begin
      cyc();
      i_start = 1'b0;
    end
    i_flush = 1'b1;
    #3;
    got = obs();
    n_cmp++;
    if (got !== {5'b01001, m_sgn, m_isdiv}) begin
      n_fail++;
      $display("FAIL flush_cycle got=%b exp=%b", got, {5'b01001, m_sgn, m_isdiv});
    end
    for (int k = 0; k < 30; k++) begin
      cyc();
      i_flush = 1'b0;
      #3;
      got = obs();
      n_cmp++;
      if (got !== {5'b00000, m_sgn, m_isdiv}) begin
        n_fail++;
        $display("FAIL flush_after k=%0d got=%b exp=%b", k, got, {5'b00000, m_sgn, m_isdiv});
      end
    end
    cyc();
    run_request(2'b00, 1'b0, 1'b0, "umul_after_flush");
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic       dz;
    int         base_done;
    int         base_acc;
    int         exp_done;
    base_done = n_done_seen;
    base_acc  = n_accepted;
    exp_done  = 0;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(3));
      dz = ($urandom_range(3) == 0);
      if (!(op[1] && dz)) exp_done++;
      run_request(op, dz, 1'b1, "random");
    end
    n_cmp++;
    if ((n_done_seen - base_done) !== exp_done || (n_accepted - base_acc) !== 24) begin
      n_fail++;
      $display("FAIL done_count got=%0d exp=%0d", n_done_seen - base_done, exp_done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] got;
    cyc();
    i_start = 1'b1; i_op = 2'b11; i_divisor_zero = 1'b0; i_flush = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      i_start = 1'b0;
    end
    i_reset = 1'b1;
    #3;
    n_cmp++;
    if (o_stall_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_stall got=%b exp=0", o_stall_c);
    end
    cyc();
    i_reset = 1'b0;
    m_sgn = 1'b0; m_isdiv = 1'b0;
    #3;
    got = obs();
    n_cmp++;
    if (got !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got=%b exp=%b", got, 7'b0);
    end
    cyc();
    i_flush = 1'b1; i_start = 1'b1; i_op = 2'b11; i_divisor_zero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      i_flush = 1'b0; i_start = 1'b0;
      #3;
      got = obs();
      n_cmp++;
      if (got !== 7'b0) begin
        n_fail++;
        $display("FAIL flush_beats_start k=%0d got=%b exp=%b", k, got, 7'b0);
      end
    end
    cyc();
    run_request(2'b01, 1'b0, 1'b0, "smul_after_reset");
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_op = 2'b00; i_divisor_zero = 1'b0; i_flush = 1'b0;
    m_sgn = 1'b0; m_isdiv = 1'b0;
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
